// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller.
// Captures completed frames {framing_error, data} into a first-word-fall-through FIFO.
// It applies the overrun policy, keeps saturating framing-error and drop counters, and raises
// a registered level interrupt on either of two conditions: the FIFO reaching a threshold, or
// the line staying idle while data waits.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_en           capture enable; frames are ignored entirely while low
//   baud_tick       baud strobe used to time the idle interrupt
//   rx_ready        one-cycle frame-complete strobe, qualifies rx_data/framing_error
//   rd_en           host pop request (ignored while empty)
//   clr_stats       clears counters and the sticky overrun flag
//   rd_valid        FIFO non-empty; rd_data/rd_ferr show the head entry
//   fifo_count      occupancy 0..DEPTH
//   overrun         sticky: a frame was lost because the FIFO was full
//   ferr_cnt        framing-error frames seen (saturating)
//   drop_cnt        frames lost to overrun (saturating)
//   irq             level interrupt
module uart_rx_ctrl #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IRQ_LEVEL  = 8,
    parameter int unsigned IDLE_TICKS = 32,
    parameter bit          DROP_ERR   = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_en,
    input  logic                   baud_tick,
    input  logic                   rx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   framing_error,
    input  logic                   rd_en,
    input  logic                   clr_stats,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    output logic                   rd_ferr,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overrun,
    output logic [CNT_W-1:0]       ferr_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   irq
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned IdleW = $clog2(IDLE_TICKS + 1);

    localparam logic [PtrW:0]    FullCount = DEPTH[PtrW:0];
    localparam logic [PtrW:0]    IrqCount  = IRQ_LEVEL[PtrW:0];
    localparam logic [IdleW-1:0] IdleLimit = IDLE_TICKS[IdleW-1:0];
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             idle_flag_q, idle_flag_d;
    logic             irq_q, irq_d;

    logic capture, store, pop, full, push, lost;

    always_comb begin
        capture = rx_ready & rx_en;
        // With DROP_ERR a bad frame is still "captured" (counted) but never stored.
        store   = capture & ~(DROP_ERR & framing_error);
        pop     = rd_en & (count_q != '0);
        full    = (count_q == FullCount);
        // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
        push    = store & (~full | pop);
        lost    = store & full & ~pop;

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        ferr_cnt_d  = ferr_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        idle_flag_d = idle_flag_q;

        if (push) begin
            mem_d[wr_ptr_q] = {framing_error, rx_data};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase

        // Clear first so that an event in the same cycle still registers.
        if (clr_stats) begin
            ferr_cnt_d = '0;
            drop_cnt_d = '0;
            overrun_d  = 1'b0;
        end
        if (capture && framing_error && (ferr_cnt_d != CntMax)) begin
            ferr_cnt_d = ferr_cnt_d + CNT_W'(1);
        end
        if (lost) begin
            overrun_d = 1'b1;
            if (drop_cnt_d != CntMax) begin
                drop_cnt_d = drop_cnt_d + CNT_W'(1);
            end
        end

        // Idle timer only runs while data sits in the FIFO with no traffic.
        if (capture || pop || (count_q == '0)) begin
            idle_cnt_d  = '0;
            idle_flag_d = 1'b0;
        end else begin
            if (baud_tick && (idle_cnt_q != IdleLimit)) begin
                idle_cnt_d = idle_cnt_q + IdleW'(1);
            end
            if (idle_cnt_d == IdleLimit) begin
                idle_flag_d = 1'b1;
            end
        end

        irq_d = (count_d >= IrqCount) | idle_flag_d;
    end

    // Storage is not reset; rd_data is masked while the FIFO is empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            ferr_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            idle_flag_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            ferr_cnt_q  <= ferr_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            idle_flag_q <= idle_flag_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        rd_valid   = (count_q != '0);
        rd_data    = rd_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
        rd_ferr    = rd_valid ? mem_q[rd_ptr_q][8] : 1'b0;
        fifo_count = count_q;
        overrun    = overrun_q;
        ferr_cnt   = ferr_cnt_q;
        drop_cnt   = drop_cnt_q;
        irq        = irq_q;
    end

endmodule
